// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and the PLL / VGA logic around it.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic [2:0] state;

  // Sequencer side
  modport master (
    input  pll_locked, restart,
    output pll_rst, sys_rst_n, ready, fail, retry_cnt, lost_cnt, state
  );

  // PLL / system side
  modport slave (
    output pll_locked, restart,
    input  pll_rst, sys_rst_n, ready, fail, retry_cnt, lost_cnt, state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Sequences the pixel-clock PLL through reset, lock wait (with timeout/retry) and lock
// qualification on the reference clock; the system reset is released only in RUN.
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned CNT_W        = 17
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOST_W  = 8;

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);
  localparam logic [LOST_W-1:0]  LOST_SAT     = '1;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               w_lock_s;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   w_timer_next;
  logic [RETRY_W-1:0] r_retry_cnt;
  logic [RETRY_W-1:0] w_retry_next;
  logic [LOST_W-1:0]  r_lost_cnt;
  logic [LOST_W-1:0]  w_lost_next;

  logic               r_pll_rst;
  logic               r_sys_rst_n;
  logic               r_ready;
  logic               r_fail;
  logic               w_pll_rst;
  logic               w_sys_rst_n;
  logic               w_ready;
  logic               w_fail;

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lock_s = r_sync2;

  // State register, shared timer, counters and registered outputs
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HOLD;
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_lost_cnt  <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_timer     <= w_timer_next;
      r_retry_cnt <= w_retry_next;
      r_lost_cnt  <= w_lost_next;
      r_pll_rst   <= w_pll_rst;
      r_sys_rst_n <= w_sys_rst_n;
      r_ready     <= w_ready;
      r_fail      <= w_fail;
    end
  end

  // Next state and counter updates; restart overrides everything
  always_comb begin
    w_next_state = r_state;
    w_retry_next = r_retry_cnt;
    w_lost_next  = r_lost_cnt;
    if (bus.restart) begin
      w_next_state = ST_HOLD;
      w_retry_next = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_timer == HOLD_LAST) w_next_state = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_next_state = ST_STABLE;
          end else if (r_timer == TIMEOUT_LAST) begin
            if (r_retry_cnt == RETRY_MAX) begin
              w_next_state = ST_FAIL;
            end else begin
              w_next_state = ST_HOLD;
              w_retry_next = r_retry_cnt + RETRY_W'(1);
            end
          end
        end
        ST_STABLE: begin
          if (!w_lock_s) begin
            w_next_state = ST_WAIT_LOCK;
          end else if (r_timer == STABLE_LAST) begin
            w_next_state = ST_RUN;
            w_retry_next = '0;
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            w_next_state = ST_HOLD;
            if (r_lost_cnt != LOST_SAT) w_lost_next = r_lost_cnt + LOST_W'(1);
          end
        end
        ST_FAIL: w_next_state = ST_FAIL;
        default: w_next_state = ST_HOLD;
      endcase
    end
  end

  assign w_timer_next = (bus.restart || (w_next_state != r_state)) ? '0 : r_timer + CNT_W'(1);

  // Outputs decoded from next state so they move on the same edge as the state
  always_comb begin
    w_pll_rst   = 1'b1;
    w_sys_rst_n = 1'b0;
    w_ready     = 1'b0;
    w_fail      = 1'b0;
    case (w_next_state)
      ST_WAIT_LOCK, ST_STABLE: w_pll_rst = 1'b0;
      ST_RUN: begin
        w_pll_rst   = 1'b0;
        w_sys_rst_n = 1'b1;
        w_ready     = 1'b1;
      end
      ST_FAIL: w_fail = 1'b1;
      default: ;
    endcase
  end

  assign bus.pll_rst   = r_pll_rst;
  assign bus.sys_rst_n = r_sys_rst_n;
  assign bus.ready     = r_ready;
  assign bus.fail      = r_fail;
  assign bus.retry_cnt = r_retry_cnt;
  assign bus.lost_cnt  = r_lost_cnt;
  assign bus.state     = r_state;

endmodule
